// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

   localparam int unsigned DATA_W          = 32;
   localparam int unsigned REG_W           = 5;
   localparam int unsigned CTRL_W          = 2;
   localparam int unsigned CNT_W           = 8;
   localparam int unsigned MC_READ         = 0;
   localparam int unsigned MC_WRITE        = 1;
   localparam int unsigned TIMEOUT_DEFAULT = 15;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   // Request payload held on the data-memory bus for the duration of an access.
   typedef struct packed {
      logic              we;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_bus_t;

   function automatic logic is_word_aligned(input logic [DATA_W-1:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts BUSY cycles without an ack; flags when the abort limit is reached.
module mem_wait_timer
   import mem_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CNT_W-1:0] count;

   // Clear has priority so a finishing access always leaves the count at zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: runs load/store over the req/ack bus, stalls upstream while busy,
// and holds the MEM/WB output register.
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [CTRL_W-1:0] M_control_in,
   input  logic [CTRL_W-1:0] WB_control_in,
   input  logic [DATA_W-1:0] ALU_out_in,
   input  logic [DATA_W-1:0] data_write_in,
   input  logic [REG_W-1:0]  rw_in,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall,
   output logic [CTRL_W-1:0] WB_control_out,
   output logic [DATA_W-1:0] read_data_out,
   output logic [DATA_W-1:0] ALU_out_out,
   output logic [REG_W-1:0]  rw_out,
   output logic              mem_err
);

   state_e            state_q, state_d;
   mem_bus_t          bus_q, bus_d;
   logic              req_q, req_d;
   logic              err_q, err_d;
   logic [CTRL_W-1:0] wb_q, wb_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] alu_q, alu_d;
   logic [REG_W-1:0]  rw_q, rw_d;

   logic mem_read, mem_write, access, illegal, legal;
   logic tmr_clear, tmr_en, expired;

   assign mem_read  = M_control_in[MC_READ];
   assign mem_write = M_control_in[MC_WRITE];
   assign access    = mem_read ^ mem_write;
   assign illegal   = (mem_read & mem_write) | (access & ~is_word_aligned(ALU_out_in));
   assign legal     = access & ~illegal;

   mem_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (tmr_clear),
      .enable  (tmr_en),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         bus_q   <= '0;
         req_q   <= 1'b0;
         err_q   <= 1'b0;
         wb_q    <= '0;
         rdata_q <= '0;
         alu_q   <= '0;
         rw_q    <= '0;
      end else begin
         state_q <= state_d;
         bus_q   <= bus_d;
         req_q   <= req_d;
         err_q   <= err_d;
         wb_q    <= wb_d;
         rdata_q <= rdata_d;
         alu_q   <= alu_d;
         rw_q    <= rw_d;
      end
   end

   // Next-state and next-register values; the timer is pre-counted on entry so
   // the count equals the number of BUSY cycles spent so far.
   always_comb begin
      state_d   = state_q;
      bus_d     = bus_q;
      req_d     = req_q;
      err_d     = err_q;
      wb_d      = WB_control_in;
      rdata_d   = '0;
      alu_d     = ALU_out_in;
      rw_d      = rw_in;
      stall     = 1'b0;
      tmr_clear = 1'b0;
      tmr_en    = 1'b0;

      case (state_q)
         IDLE: begin
            if (legal) begin
               state_d = BUSY;
               req_d   = 1'b1;
               bus_d   = '{we: mem_write, addr: ALU_out_in, wdata: data_write_in};
               wb_d    = '0;
               stall   = 1'b1;
               tmr_en  = 1'b1;
            end else begin
               tmr_clear = 1'b1;
               if (illegal) begin
                  err_d = 1'b1;
                  wb_d  = '0;
               end
            end
         end
         BUSY: begin
            if (mem_ack) begin
               state_d   = IDLE;
               req_d     = 1'b0;
               rdata_d   = bus_q.we ? '0 : mem_rdata;
               tmr_clear = 1'b1;
            end else if (expired) begin
               state_d   = IDLE;
               req_d     = 1'b0;
               err_d     = 1'b1;
               wb_d      = '0;
               tmr_clear = 1'b1;
            end else begin
               wb_d   = '0;
               stall  = 1'b1;
               tmr_en = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign mem_req        = req_q;
   assign mem_we         = bus_q.we;
   assign mem_addr       = bus_q.addr;
   assign mem_wdata      = bus_q.wdata;
   assign mem_err        = err_q;
   assign WB_control_out = wb_q;
   assign read_data_out  = rdata_q;
   assign ALU_out_out    = alu_q;
   assign rw_out         = rw_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table with a result scoreboard, plus
// hand-written reset-during-access sequence.
module tb_mem_access_stage;

   localparam int unsigned TMO = 15;

   logic        clk;
   logic        reset;
   logic [1:0]  M_control_in;
   logic [1:0]  WB_control_in;
   logic [31:0] ALU_out_in;
   logic [31:0] data_write_in;
   logic [4:0]  rw_in;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        stall;
   logic [1:0]  WB_control_out;
   logic [31:0] read_data_out;
   logic [31:0] ALU_out_out;
   logic [4:0]  rw_out;
   logic        mem_err;

   mem_access_stage #(.TIMEOUT(TMO)) dut (
      .clk            (clk),
      .reset          (reset),
      .M_control_in   (M_control_in),
      .WB_control_in  (WB_control_in),
      .ALU_out_in     (ALU_out_in),
      .data_write_in  (data_write_in),
      .rw_in          (rw_in),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .mem_ack        (mem_ack),
      .stall          (stall),
      .WB_control_out (WB_control_out),
      .read_data_out  (read_data_out),
      .ALU_out_out    (ALU_out_out),
      .rw_out         (rw_out),
      .mem_err        (mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  mc;
      logic [1:0]  wb;
      logic [31:0] alu;
      logic [31:0] wdata;
      logic [4:0]  rw;
      int          k;       // BUSY cycle in which ack is given, 0 = never
      logic [31:0] rdata;
      int          busy;    // expected cycles with mem_req high
      int          stalls;  // expected cycles with stall high
      bit          kill;    // no MEM/WB result expected
      bit          err;     // expected mem_err afterwards
   } vec_t;

   typedef struct {
      logic [1:0]  wb;
      logic [31:0] alu;
      logic [4:0]  rw;
      logic [31:0] rdata;
   } res_t;

   res_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] mc, input logic [1:0] wb,
                               input logic [31:0] alu, input logic [31:0] wdata,
                               input logic [4:0] rw, input int k, input logic [31:0] rdata,
                               input int busy, input int stalls, input bit kill, input bit err);
      vec_t v;
      v.mc = mc; v.wb = wb; v.alu = alu; v.wdata = wdata; v.rw = rw; v.k = k;
      v.rdata = rdata; v.busy = busy; v.stalls = stalls; v.kill = kill; v.err = err;
      return v;
   endfunction

   task automatic drive_nop();
      M_control_in  = 2'b00;
      WB_control_in = 2'b00;
      ALU_out_in    = 32'h0;
      data_write_in = 32'h0;
      rw_in         = 5'd0;
      mem_ack       = 1'b0;
      mem_rdata     = 32'h0;
   endtask

   // Scoreboard: every non-bubble MEM/WB output must match the oldest expected result.
   always @(negedge clk) begin
      if (reset && WB_control_out != 2'b00) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: got wb=%b alu=%h with nothing expected", WB_control_out, ALU_out_out);
         end else begin
            res_t e;
            e = sb_q.pop_front();
            check("sb_wb", 32'(WB_control_out), 32'(e.wb));
            check("sb_alu", ALU_out_out, e.alu);
            check("sb_rw", 32'(rw_out), 32'(e.rw));
            check("sb_rdata", read_data_out, e.rdata);
         end
      end
   end

   // Called just after a rising edge; returns just after the edge that retires the instruction.
   task automatic issue(input vec_t v, input int idx);
      int busy_n;
      int stall_n;
      bit done;
      res_t r;
      M_control_in  = v.mc;
      WB_control_in = v.wb;
      ALU_out_in    = v.alu;
      data_write_in = v.wdata;
      rw_in         = v.rw;
      mem_ack       = 1'b0;
      mem_rdata     = 32'h0;
      if (!v.kill) begin
         r.wb = v.wb; r.alu = v.alu; r.rw = v.rw;
         r.rdata = (v.mc == 2'b01) ? v.rdata : 32'h0;
         sb_q.push_back(r);
      end
      busy_n = 0; stall_n = 0; done = 1'b0;
      for (int c = 0; c < 300 && !done; c++) begin
         if (mem_req) begin
            busy_n++;
            if (busy_n == 1) begin
               check($sformatf("v%0d_we", idx), 32'(mem_we), 32'(v.mc[1]));
               check($sformatf("v%0d_addr", idx), mem_addr, v.alu);
               check($sformatf("v%0d_wdata", idx), mem_wdata, v.wdata);
            end
            if (busy_n == v.k) begin
               mem_ack   = 1'b1;
               mem_rdata = v.rdata;
            end
         end
         #1;
         if (stall) stall_n++;
         else done = 1'b1;
         @(posedge clk);
         #1;
         mem_ack   = 1'b0;
         mem_rdata = 32'h0;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL v%0d_hang: stall still %b after 300 cycles, want 0", idx, stall);
      end
      check($sformatf("v%0d_busy", idx), 32'(busy_n), 32'(v.busy));
      check($sformatf("v%0d_stalls", idx), 32'(stall_n), 32'(v.stalls));
      check($sformatf("v%0d_req_end", idx), 32'(mem_req), 32'd0);
      check($sformatf("v%0d_wb_end", idx), 32'(WB_control_out), v.kill ? 32'd0 : 32'(v.wb));
      check($sformatf("v%0d_err", idx), 32'(mem_err), 32'(v.err));
      drive_nop();
   endtask

   vec_t vecs[11];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk(2'b00, 2'b11, 32'h0000_1234, 32'h0,         5'd7,  0,   32'h0,         0,   0,   0, 0);
      vecs[1]  = mk(2'b01, 2'b01, 32'h0000_0100, 32'h1111_2222, 5'd3,  2,   32'hDEAD_BEEF, 2,   2,   0, 0);
      vecs[2]  = mk(2'b10, 2'b10, 32'h0000_0040, 32'hA5A5_A5A5, 5'd0,  1,   32'h5555_AAAA, 1,   1,   0, 0);
      vecs[3]  = mk(2'b00, 2'b01, 32'hFFFF_FFFC, 32'h0,         5'd31, 0,   32'h0,         0,   0,   0, 0);
      vecs[4]  = mk(2'b01, 2'b11, 32'h0000_0200, 32'h0,         5'd12, TMO, 32'h0BAD_F00D, TMO, TMO, 0, 0);
      vecs[5]  = mk(2'b10, 2'b01, 32'h0000_FFFC, 32'h1357_9BDF, 5'd4,  3,   32'h0,         3,   3,   0, 0);
      vecs[6]  = mk(2'b01, 2'b11, 32'h0000_0102, 32'h0,         5'd5,  1,   32'hFFFF_FFFF, 0,   0,   1, 1);
      vecs[7]  = mk(2'b00, 2'b10, 32'h0000_ABCD, 32'h0,         5'd8,  0,   32'h0,         0,   0,   0, 1);
      vecs[8]  = mk(2'b11, 2'b11, 32'h0000_0080, 32'h0,         5'd9,  1,   32'h0,         0,   0,   1, 1);
      vecs[9]  = mk(2'b01, 2'b11, 32'h0000_0300, 32'h0,         5'd10, 0,   32'h0,         TMO, TMO, 1, 1);
      vecs[10] = mk(2'b01, 2'b01, 32'h0000_0304, 32'h0,         5'd11, 1,   32'hCAFE_0001, 1,   1,   0, 1);

      drive_nop();
      reset = 1'b0;
      #12;
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_wb", 32'(WB_control_out), 32'd0);
      check("rst_rdata", read_data_out, 32'd0);
      check("rst_alu", ALU_out_out, 32'd0);
      check("rst_err", 32'(mem_err), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      #3 reset = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 11; i++) begin
         issue(vecs[i], i);
         @(posedge clk);
         #1;
      end

      // Reset pulled low during the third BUSY cycle of a load that never gets acked.
      M_control_in  = 2'b01;
      WB_control_in = 2'b11;
      ALU_out_in    = 32'h0000_0400;
      data_write_in = 32'h7777_7777;
      rw_in         = 5'd9;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
      end
      check("mid_req_before", 32'(mem_req), 32'd1);
      #2;
      reset = 1'b0;
      drive_nop();
      #1;
      check("mid_req", 32'(mem_req), 32'd0);
      check("mid_addr", mem_addr, 32'd0);
      check("mid_wdata", mem_wdata, 32'd0);
      check("mid_wb", 32'(WB_control_out), 32'd0);
      check("mid_alu", ALU_out_out, 32'd0);
      check("mid_rw", 32'(rw_out), 32'd0);
      check("mid_err", 32'(mem_err), 32'd0);
      check("mid_stall", 32'(stall), 32'd0);
      @(posedge clk);
      #2 reset = 1'b1;
      @(posedge clk);
      #1;
      issue(mk(2'b01, 2'b10, 32'h0000_0500, 32'h0, 5'd14, 2, 32'h1234_5678, 2, 2, 0, 0), 11);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage of the MIPS-DLX core. It sits directly downstream of the EX/MEM latch and consumes its M/WB control, ALU result, store data and destination register. It runs load/store accesses over a req/ack data-memory bus and stalls the upstream pipeline while an access is outstanding. It also contains the MEM/WB output register that feeds the write-back stage.

## Interface
Parameters:
- TIMEOUT, 15: maximum BUSY cycles without `mem_ack` before the access is aborted (range 1–255).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-low
- M_control_in  in  2  bit1 MemWrite, bit0 MemRead (from EX/MEM)
- WB_control_in  in  2  write-back control, passed through
- ALU_out_in  in  32  ALU result; the memory address for loads/stores
- data_write_in  in  32  store data
- rw_in  in  5  destination register
- mem_req  out  1  bus request
- mem_we  out  1  1 = write, 0 = read; valid while `mem_req`
- mem_addr  out  32  word address; valid while `mem_req`
- mem_wdata  out  32  store data; valid while `mem_req`
- mem_rdata  in  32  read data; valid with `mem_ack`
- mem_ack  in  1  access complete
- stall  out  1  combinational; 1 = upstream latches must hold
- WB_control_out  out  2  to MEM/WB
- read_data_out  out  32  load data
- ALU_out_out  out  32  ALU result passthrough
- rw_out  out  5  destination register passthrough
- mem_err  out  1  sticky error flag

## Operation
- Access types: `access` = MemRead XOR MemWrite.
- Illegal access: MemRead and MemWrite both set, or an access with ALU_out_in[1:0] ≠ 0.
  - No bus cycle is issued.
  - `mem_err` is set.
  - The instruction is killed: WB_control_out <= 0 at the next edge.
- FSM states: IDLE and BUSY.
- IDLE, no access:
  - At each edge, register WB_control/ALU_out/rw from the inputs.
  - read_data_out <= 0.
- IDLE, legal access:
  - At the edge, go to BUSY.
  - Latch mem_addr = ALU_out_in, mem_we = MemWrite, mem_wdata = data_write_in.
  - mem_req <= 1.
  - WB_control_out <= 0 (bubble).
- BUSY, mem_ack = 1:
  - At the edge, return to IDLE and set mem_req <= 0.
  - Register the outputs from the held inputs.
  - read_data_out <= mem_rdata for a load, 0 for a store.
- BUSY, no ack:
  - The wait counter increments.
  - WB_control_out <= 0 at every edge (bubble).
- Timeout: when the counter reaches TIMEOUT with no ack:
  - Abort: mem_req <= 0, go to IDLE, mem_err <= 1.
  - WB_control_out <= 0; the instruction is dropped.
- stall = (IDLE && legal access) || (BUSY && !mem_ack && counter < TIMEOUT).
- mem_ack in IDLE is ignored.
- mem_err clears only on reset.
- Upstream must hold all *_in stable while stall = 1.

## Timing
- All outputs reset to 0 asynchronously: mem_req, mem_we, mem_addr, mem_wdata, stall-driving state, counter, WB_control_out, read_data_out, ALU_out_out, rw_out, mem_err. State resets to IDLE.
- Non-memory instruction: 1 cycle through the stage; stall never asserts.
- Load/store with ack in the k-th BUSY cycle (k ≥ 1):
  - Outputs are valid after k+1 edges.
  - stall is high for k cycles.
  - Exactly one MEM/WB result is produced, preceded by k bubbles.
- mem_req rises one edge after the access enters IDLE. It falls at the edge where ack is sampled, or at the timeout edge.
- Reset asserted mid-BUSY:
  - mem_req drops immediately and the FSM goes to IDLE.
  - No result is produced and mem_err is not set.
- Ack arriving exactly on the TIMEOUT cycle: ack wins; normal completion, no error.

## Structure
- Package `mem_stage_pkg`:
  - State enum (IDLE, BUSY).
  - Bit indices MC_READ=0, MC_WRITE=1.
  - Default TIMEOUT constant.
- Sub-module `mem_wait_timer`: 8-bit counter with clear/enable, `expired` = (count == TIMEOUT), async active-low reset.
- The FSM, bus registers and MEM/WB register live in the top module.

## Test plan
- ALU op: M_control_in=00, WB=11, ALU_out=0x1234, rw=7 -> next edge WB_control_out=11, ALU_out_out=0x1234, rw_out=7; stall never 1.
- Load with 2-cycle ack: MemRead, addr 0x100, ack high in the 2nd BUSY cycle with rdata=0xDEADBEEF -> stall high 2 cycles, 2 bubbles, then read_data_out=0xDEADBEEF, mem_err=0.
- Store with immediate ack: MemWrite, addr 0x40, data 0xA5A5A5A5 -> mem_we=1, mem_addr=0x40, mem_wdata=0xA5A5A5A5 for 1 cycle, read_data_out=0.
- Misaligned load at 0x102, and M_control=11 -> no mem_req, WB_control_out=00, mem_err=1 and stays 1.
- No ack, TIMEOUT=15 -> mem_req high 15 cycles, then drops, mem_err=1, stall low, FSM in IDLE.
- reset pulled low in the 3rd BUSY cycle -> mem_req=0 immediately, all outputs 0, then a normal load completes after reset is released.
